// File: rtl/uart_rx_if.sv
// Receive-side bundle of a UART: serial line in, received byte and status out.
// The receiver connects through the slave modport; whoever drives the line
// and consumes the bytes uses the master modport.
interface uart_rx_if;
  logic       rx;     // serial line, idle high, 8N1
  logic [7:0] rxdw;   // last received data byte
  logic       rxrdy;  // one-cycle pulse: rxdw valid and new
  logic       ferr;   // one-cycle pulse: stop bit sampled low
  logic       busy;   // frame in progress

  modport master (
    output rx,
    input  rxdw,
    input  rxrdy,
    input  ferr,
    input  busy
  );

  modport slave (
    input  rx,
    output rxdw,
    output rxrdy,
    output ferr,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronised, the start bit is confirmed at
// its centre, data bits are sampled at their centres LSB first and the stop
// bit decides between a data-ready pulse and a framing-error pulse.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_s;
  logic [7:0]    data;
  logic          rdy;
  logic          err;
  logic          active;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  // so a reset never looks like a start edge.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together and simulation matches the synthesised netlist.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data     <= '0;
      rdy      <= 1'b0;
      err      <= 1'b0;
      active   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // A line still low after a framing error simply restarts a frame.
          if (!rx_s) begin
            state  <= START;
            active <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == HALF) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              state  <= IDLE;
              active <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;  // wraps 7 -> 0 on the way out
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            state    <= IDLE;
            active   <= 1'b0;
            if (rx_s) begin
              data <= shreg;
              rdy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rxdw  = data;
  assign bus.rxrdy = rdy;
  assign bus.ferr  = err;
  assign bus.busy  = active;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reset state, single and
// back-to-back frames, framing error, start glitch and mid-frame reset.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Free-running cycle count and an output monitor sampled on the falling edge.
  int         cyc = 0;
  int         rdy_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         bad_chg = 0;
  int         rdy_cyc = 0;
  logic [7:0] data_log [16];
  logic [7:0] prev_rxdw = 8'h00;
  logic       rst_q = 1'b1;
  logic       rst_qq = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rxrdy === 1'b1) begin
      if (rdy_cnt < 16) data_log[rdy_cnt] = bus.rxdw;
      rdy_cnt++;
      rdy_cyc = cyc;
    end
    if (bus.ferr === 1'b1) ferr_cnt++;
    if (bus.rxrdy === 1'b1 && bus.ferr === 1'b1) both_cnt++;
    if (!rst && !rst_q && !rst_qq && bus.rxrdy !== 1'b1 && bus.rxdw !== prev_rxdw)
      bad_chg++;
    prev_rxdw = bus.rxdw;
    rst_qq    = rst_q;
    rst_q     = rst;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame starting at the current falling edge and returns at
  // the falling edge where the stop bit ends, with the line high again.
  int fall_cyc = 0;
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    bus.rx   = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int  base_rdy;
  int  base_ferr;
  bit  seen_hi;
  bit  seen_lo;
  int  lat;

  initial begin
    // Reset held for 10 cycles with the line idle.
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_rxdw",  32'(bus.rxdw),  32'h00);
    check("reset_rxrdy", 32'(bus.rxrdy), 32'h0);
    check("reset_ferr",  32'(bus.ferr),  32'h0);
    check("reset_busy",  32'(bus.busy),  32'h0);
    rst = 1'b0;
    idle(5);

    // Single frame 0xF0.
    send_byte(8'hF0, 1'b1);
    idle(3);
    lat = rdy_cyc - fall_cyc;
    check("f0_rdy_count", 32'(rdy_cnt),     32'd1);
    check("f0_rxdw",      32'(bus.rxdw),    32'hF0);
    check("f0_logged",    32'(data_log[0]), 32'hF0);
    check("f0_no_ferr",   32'(ferr_cnt),    32'd0);
    check("f0_busy_low",  32'(bus.busy),    32'h0);
    // 2 + 8 + 144 + 1 = 155, +-1 for edge alignment.
    check("f0_latency_window", 32'(lat >= 154 && lat <= 156), 32'd1);

    // Back-to-back 0x0F then 0xA5 with no idle gap.
    send_byte(8'h0F, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(3);
    check("b2b_rdy_count", 32'(rdy_cnt),     32'd3);
    check("b2b_first",     32'(data_log[1]), 32'h0F);
    check("b2b_second",    32'(data_log[2]), 32'hA5);
    check("b2b_rxdw",      32'(bus.rxdw),    32'hA5);

    // Frame 0x3C with the stop bit held low: framing error, byte discarded.
    send_byte(8'h3C, 1'b0);
    idle(40);
    check("ferr_count",   32'(ferr_cnt),  32'd1);
    check("ferr_no_rdy",  32'(rdy_cnt),   32'd3);
    check("ferr_rxdw",    32'(bus.rxdw),  32'hA5);
    check("ferr_busy",    32'(bus.busy),  32'h0);

    // Four-cycle low glitch on an idle line.
    base_rdy  = rdy_cnt;
    base_ferr = ferr_cnt;
    seen_hi   = 1'b0;
    seen_lo   = 1'b0;
    bus.rx    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) bus.rx = 1'b1;
      @(negedge clk);
      if (bus.busy === 1'b1) seen_hi = 1'b1;
      if (seen_hi && bus.busy === 1'b0) seen_lo = 1'b1;
    end
    check("glitch_busy_rose", 32'(seen_hi),  32'd1);
    check("glitch_busy_fell", 32'(seen_lo),  32'd1);
    check("glitch_no_rdy",    32'(rdy_cnt),  32'(base_rdy));
    check("glitch_no_ferr",   32'(ferr_cnt), 32'(base_ferr));

    // Reset in the middle of data bit 3 of 0x55, then a clean 0xF0.
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = i[0] ? 1'b0 : 1'b1;  // 0x55 LSB first: 1,0,1
      repeat (CPB) @(negedge clk);
    end
    bus.rx = 1'b0;                  // bit 3 of 0x55
    repeat (CPB / 2) @(negedge clk);
    check("abort_busy_before_rst", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(200);
    check("abort_busy",    32'(bus.busy),  32'h0);
    check("abort_no_rdy",  32'(rdy_cnt),   32'(base_rdy));
    check("abort_no_ferr", 32'(ferr_cnt),  32'(base_ferr));
    check("abort_rxdw",    32'(bus.rxdw),  32'h00);
    send_byte(8'hF0, 1'b1);
    idle(3);
    check("resume_rdy_count", 32'(rdy_cnt),             32'(base_rdy + 1));
    check("resume_rxdw",      32'(bus.rxdw),            32'hF0);
    check("resume_logged",    32'(data_log[base_rdy]),  32'hF0);
    check("resume_no_ferr",   32'(ferr_cnt),            32'(base_ferr));

    // Whole-run properties gathered by the monitor.
    check("never_rdy_and_ferr", 32'(both_cnt), 32'd0);
    check("rxdw_only_with_rdy", 32'(bad_chg),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
